hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Sequences the decode stage of the five-stage pipeline.
- Keeps a per-register scoreboard of in-flight writes and stalls decode on read-after-write hazards that forwarding cannot cover.
- Runs a flush FSM that squashes the F/D and D/E buffers when EX resolves a taken branch.
- Sits beside the decode stage; drives its buffer enables and the flush lines.

Parameters:
- NREG, 8, number of architectural registers (address width = clog2(NREG) = 3).
- ALU_LAT, 0, cycles before an ALU result is forwardable to a decode-stage reader.
- LOAD_LAT, 1, cycles before a load result is forwardable.
- WB_DIST, 3, cycles from issue until the register file holds the result (no-forwarding path).
- FLUSH_CYCLES, 2, cycles flush lines stay asserted after a taken branch (1..3).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- dec_valid  in  1  decode holds a real instruction
- src  in  3  source register address of the decode instruction
- dst  in  3  destination/second-source address of the decode instruction
- use_src  in  1  decode instruction reads src
- use_dst  in  1  decode instruction reads dst
- reg_write  in  1  decode instruction writes dst (WB_signals regWrite)
- mem_read  in  1  decode instruction is a load (MEM_signals memRead)
- branch_taken  in  1  EX resolved a taken branch this cycle
- stall  out  1  hold PC and F/D; inject bubble into D/E
- issue  out  1  decode instruction advances into D/E this cycle
- flush_fd  out  1  squash F/D buffer
- flush_de  out  1  squash D/E buffer
- busy_mask  out  NREG  bit r set when scoreboard count[r] != 0
- stall_cnt  out  16  saturating count of stall cycles

Behaviour:
- Reset (clk edge with rst=1):
  - All scoreboard counts = 0; FSM = IDLE; stall_cnt = 0.
  - Outputs stall, issue, flush_fd, flush_de = 0; busy_mask = 0.
  - Reset mid-flush or mid-stall aborts the operation immediately.
- Scoreboard: count[r] is 2 bits. Every cycle each nonzero count decrements by 1.
- Hazard (combinational):
  - haz = dec_valid & ((use_src & count[src] != 0) | (use_dst & count[dst] != 0)).
  - The check uses pre-decrement values.
- stall = haz & (FSM == IDLE) & !branch_taken.
- issue = dec_valid & !haz & (FSM == IDLE) & !branch_taken.
- On issue with reg_write:
  - Next count[dst] = mem_read ? LOAD_LAT : ALU_LAT.
  - This write overrides the decrement for that entry in the same cycle.
- Last-issue record: lastv/lastr/lastprev hold the issue valid flag, the register written, and that register's count before the overwrite (pre-decrement).
- Flush FSM:
  - States: IDLE, FLUSH.
  - IDLE -> FLUSH on branch_taken; load flush counter with FLUSH_CYCLES-1.
  - In FLUSH the counter decrements each cycle; FLUSH -> IDLE when counter = 0.
  - flush_fd = flush_de = 1 in the branch_taken cycle and in every FLUSH cycle. issue = stall = 0 in those cycles.
- Undo on branch_taken:
  - If lastv is set, count[lastr] is restored to max(lastprev-1, 0). This squashes the wrongly-issued D/E instruction's reservation.
  - Undo takes priority over the normal decrement for that entry.
  - lastv clears every non-issue cycle.
- branch_taken while already in FLUSH reloads the counter. Flush is extended, not queued.
- Simultaneous haz and branch_taken: flush wins; stall = 0; stall_cnt does not increment.
- stall_cnt increments on each stall=1 cycle and saturates at 16'hFFFF.
- busy_mask is registered: it reflects counts after the clock edge.
- Latency: stall, issue and the flush lines are combinational from the current inputs and state. Scoreboard updates are visible to the next cycle's decode instruction.

Optional Feature:
- Macro: HAZARD_NO_FORWARDING_EN.
- Defined: every issued writer sets count[dst] = WB_DIST regardless of mem_read. Counts widen to clog2(WB_DIST+1) bits; WB_DIST=3 fits in 2 bits. Use this when the EX forwarding unit is absent.
- Undefined: the ALU_LAT/LOAD_LAT rule above applies.

Test Plan:
- Load then use: load to R2 issues, next cycle ADD reads src=R2 -> stall=1 for exactly 1 cycle, stall_cnt=1, ADD issues the following cycle, busy_mask[2] is 1 for one cycle then 0.
- ALU then use: ADD writes R3, next instruction reads R3 -> stall never asserted (ALU_LAT=0), issue=1 both cycles.
- Taken branch: branch_taken pulse for 1 cycle -> flush_fd=flush_de=1 for 2 cycles, issue=0 for 2 cycles, then IDLE. A load to R4 issued the cycle before has count[4] restored to 0 and busy_mask[4]=0.
- Branch during stall: load R1, dependent read of R1 stalls, branch_taken in the stall cycle -> stall=0, flush=1, stall_cnt unchanged.
- Reset mid-flush: assert rst in the second FLUSH cycle -> next cycle all outputs 0, busy_mask=0, stall_cnt=0.
- HAZARD_NO_FORWARDING_EN defined: ADD writes R5, consumer of R5 follows immediately -> stall=1 for 3 cycles, stall_cnt=3.

Source files
------------

// File: rtl/hazard_controller_if.sv
// Decode-stage hazard/flush control bundle between the decode stage and hazard_controller.
interface hazard_controller_if #(
    parameter int NREG = 8
);
    localparam int AW = $clog2(NREG);

    logic            dec_valid;
    logic [AW-1:0]   src;
    logic [AW-1:0]   dst;
    logic            use_src;
    logic            use_dst;
    logic            reg_write;
    logic            mem_read;
    logic            branch_taken;
    logic            stall;
    logic            issue;
    logic            flush_fd;
    logic            flush_de;
    logic [NREG-1:0] busy_mask;
    logic [15:0]     stall_cnt;

    modport master (
        output dec_valid, src, dst, use_src, use_dst, reg_write, mem_read, branch_taken,
        input  stall, issue, flush_fd, flush_de, busy_mask, stall_cnt
    );

    modport slave (
        input  dec_valid, src, dst, use_src, use_dst, reg_write, mem_read, branch_taken,
        output stall, issue, flush_fd, flush_de, busy_mask, stall_cnt
    );
endinterface

// File: rtl/hazard_controller.sv
// Decode-stage hazard controller: register scoreboard RAW stalls plus taken-branch flush FSM.
// Define HAZARD_NO_FORWARDING_EN when no EX forwarding exists: every writer then reserves WB_DIST cycles.
module hazard_controller #(
    parameter int NREG         = 8,
    parameter int ALU_LAT      = 0,
    parameter int LOAD_LAT     = 1,
    parameter int WB_DIST      = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input logic               clk,
    input logic               rst,
    hazard_controller_if.slave bus
);
    localparam int AW    = $clog2(NREG);
    localparam int CW_WB = $clog2(WB_DIST + 1);
    localparam int CW    = (CW_WB > 2) ? CW_WB : 2;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
`ifdef HAZARD_NO_FORWARDING_EN
    localparam logic [CW-1:0] WB_VAL   = CW'(WB_DIST);
`else
    localparam logic [CW-1:0] ALU_VAL  = CW'(ALU_LAT);
    localparam logic [CW-1:0] LOAD_VAL = CW'(LOAD_LAT);
`endif
    // Remaining FLUSH-state cycles after the branch cycle itself; zero means no FLUSH state needed.
    localparam logic [1:0]    FC_LOAD  = 2'(FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t          state_r, state_s;
    logic [1:0]      fcnt_r, fcnt_s;
    logic [CW-1:0]   count_r [NREG];
    logic [CW-1:0]   count_s [NREG];
    logic            lastv_r;
    logic [AW-1:0]   lastr_r;
    logic [CW-1:0]   lastprev_r;
    logic [NREG-1:0] busy_r, busy_s;
    logic [15:0]     stall_cnt_r;

    logic            haz_s, idle_s, stall_s, issue_s, flush_s;
    logic [CW-1:0]   wr_val_s, undo_val_s;

    // Hazard detection and combinational decode-stage controls.
    always_comb begin
        haz_s   = bus.dec_valid &
                  ((bus.use_src & (count_r[bus.src] != CNT_ZERO)) |
                   (bus.use_dst & (count_r[bus.dst] != CNT_ZERO)));
        idle_s  = (state_r == IDLE);
        flush_s = bus.branch_taken | (state_r == FLUSH);
        stall_s = haz_s & idle_s & ~bus.branch_taken;
        issue_s = bus.dec_valid & ~haz_s & idle_s & ~bus.branch_taken;
    end

    // Scoreboard next state: issue write, then branch undo, then plain decrement.
    always_comb begin
`ifdef HAZARD_NO_FORWARDING_EN
        wr_val_s   = WB_VAL;
`else
        wr_val_s   = bus.mem_read ? LOAD_VAL : ALU_VAL;
`endif
        undo_val_s = (lastprev_r != CNT_ZERO) ? (lastprev_r - CNT_ONE) : CNT_ZERO;
        busy_s     = {NREG{1'b0}};
        for (int r = 0; r < NREG; r++) begin
            if (issue_s && bus.reg_write && (bus.dst == AW'(r))) begin
                count_s[r] = wr_val_s;
            end else if (bus.branch_taken && lastv_r && (lastr_r == AW'(r))) begin
                count_s[r] = undo_val_s;
            end else if (count_r[r] != CNT_ZERO) begin
                count_s[r] = count_r[r] - CNT_ONE;
            end else begin
                count_s[r] = count_r[r];
            end
            busy_s[r] = (count_s[r] != CNT_ZERO);
        end
    end

    // Flush FSM next state; a branch in FLUSH reloads the counter to extend the flush.
    always_comb begin
        state_s = state_r;
        fcnt_s  = fcnt_r;
        case (state_r)
            IDLE: begin
                if (bus.branch_taken) begin
                    state_s = (FC_LOAD != 2'd0) ? FLUSH : IDLE;
                    fcnt_s  = FC_LOAD;
                end else begin
                    state_s = IDLE;
                    fcnt_s  = 2'd0;
                end
            end
            FLUSH: begin
                if (bus.branch_taken) begin
                    state_s = (FC_LOAD != 2'd0) ? FLUSH : IDLE;
                    fcnt_s  = FC_LOAD;
                end else if (fcnt_r <= 2'd1) begin
                    state_s = IDLE;
                    fcnt_s  = 2'd0;
                end else begin
                    state_s = FLUSH;
                    fcnt_s  = fcnt_r - 2'd1;
                end
            end
            default: begin
                state_s = IDLE;
                fcnt_s  = 2'd0;
            end
        endcase
    end

    // State, scoreboard, last-issue record and stall counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            fcnt_r      <= 2'd0;
            lastv_r     <= 1'b0;
            lastr_r     <= {AW{1'b0}};
            lastprev_r  <= CNT_ZERO;
            busy_r      <= {NREG{1'b0}};
            stall_cnt_r <= 16'd0;
            for (int r = 0; r < NREG; r++) begin
                count_r[r] <= CNT_ZERO;
            end
        end else begin
            state_r    <= state_s;
            fcnt_r     <= fcnt_s;
            lastv_r    <= issue_s & bus.reg_write;
            lastr_r    <= bus.dst;
            lastprev_r <= count_r[bus.dst];
            busy_r     <= busy_s;
            if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            for (int r = 0; r < NREG; r++) begin
                count_r[r] <= count_s[r];
            end
        end
    end

    assign bus.stall     = stall_s;
    assign bus.issue     = issue_s;
    assign bus.flush_fd  = flush_s;
    assign bus.flush_de  = flush_s;
    assign bus.busy_mask = busy_r;
    assign bus.stall_cnt = stall_cnt_r;
endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: directed per-cycle vectors push expected outputs, a negedge monitor compares.
module tb_hazard_controller;
    logic clk;
    logic rst;

    hazard_controller_if #(.NREG(8)) bus ();

    hazard_controller #(
        .NREG(8), .ALU_LAT(0), .LOAD_LAT(1), .WB_DIST(3), .FLUSH_CYCLES(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        stall;
        logic        issue;
        logic        flush;
        logic [7:0]  busy;
        logic [15:0] scnt;
    } exp_t;

    exp_t exp_q[$];
    int   id_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   step_id = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int id, input logic [15:0] got, input logic [15:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL step%0d %s: got %h want %h", id, name, got, want);
        end
    endtask

    // Monitor: pops one expectation per cycle and compares against the DUT outputs.
    always @(negedge clk) begin
        exp_t e;
        int   id;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            check("stall",     id, {15'd0, bus.stall},    {15'd0, e.stall});
            check("issue",     id, {15'd0, bus.issue},    {15'd0, e.issue});
            check("flush_fd",  id, {15'd0, bus.flush_fd}, {15'd0, e.flush});
            check("flush_de",  id, {15'd0, bus.flush_de}, {15'd0, e.flush});
            check("busy_mask", id, {8'd0, bus.busy_mask}, {8'd0, e.busy});
            check("stall_cnt", id, bus.stall_cnt,         e.scnt);
        end
    end

    task automatic step(input logic r, input logic v, input logic [2:0] s, input logic [2:0] d,
                        input logic us, input logic ud, input logic rw, input logic mr, input logic bt,
                        input logic e_st, input logic e_is, input logic e_fl,
                        input logic [7:0] e_busy, input logic [15:0] e_sc);
        exp_t e;
        @(posedge clk);
        #1;
        rst              = r;
        bus.dec_valid    = v;
        bus.src          = s;
        bus.dst          = d;
        bus.use_src      = us;
        bus.use_dst      = ud;
        bus.reg_write    = rw;
        bus.mem_read     = mr;
        bus.branch_taken = bt;
        e.stall = e_st;
        e.issue = e_is;
        e.flush = e_fl;
        e.busy  = e_busy;
        e.scnt  = e_sc;
        step_id++;
        exp_q.push_back(e);
        id_q.push_back(step_id);
    endtask

    initial begin
        rst              = 1'b1;
        bus.dec_valid    = 1'b0;
        bus.src          = 3'd0;
        bus.dst          = 3'd0;
        bus.use_src      = 1'b0;
        bus.use_dst      = 1'b0;
        bus.reg_write    = 1'b0;
        bus.mem_read     = 1'b0;
        bus.branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        //     rst  v    src   dst   us   ud   rw   mr   bt   st   is   fl   busy   scnt
`ifdef HAZARD_NO_FORWARDING_EN
        step(1'b0,1'b0,3'd0,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,8'h00,16'd0);
        // ADD R5, consumer of R5 stalls three cycles
        step(1'b0,1'b1,3'd0,3'd5,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,8'h00,16'd0);
        step(1'b0,1'b1,3'd5,3'd1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h20,16'd0);
        step(1'b0,1'b1,3'd5,3'd1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h20,16'd1);
        step(1'b0,1'b1,3'd5,3'd1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h20,16'd2);
        step(1'b0,1'b1,3'd5,3'd1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,8'h00,16'd3);
        // Undo restores lastprev-1 (=1), not the overwritten value minus one (=2)
        step(1'b0,1'b1,3'd0,3'd4,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,8'h00,16'd3);
        step(1'b0,1'b0,3'd0,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,8'h10,16'd3);
        step(1'b0,1'b1,3'd0,3'd4,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,8'h10,16'd3);
        step(1'b0,1'b0,3'd0,3'd0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,8'h10,16'd3);
        step(1'b0,1'b0,3'd0,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,8'h10,16'd3);
        step(1'b0,1'b0,3'd0,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,8'h00,16'd3);
`else
        step(1'b0,1'b0,3'd0,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,8'h00,16'd0);
        // Load R2 then use: one stall cycle
        step(1'b0,1'b1,3'd0,3'd2,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0,8'h00,16'd0);
        step(1'b0,1'b1,3'd2,3'd3,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h04,16'd0);
        step(1'b0,1'b1,3'd2,3'd3,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,8'h00,16'd1);
        // ALU write R3 then use: no stall
        step(1'b0,1'b1,3'd1,3'd3,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,8'h00,16'd1);
        step(1'b0,1'b1,3'd3,3'd6,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,8'h00,16'd1);
        // Load R4, taken branch: two flush cycles, R4 reservation squashed
        step(1'b0,1'b1,3'd0,3'd4,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0,8'h00,16'd1);
        step(1'b0,1'b1,3'd4,3'd5,1'b1,1'b0,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b1,8'h10,16'd1);
        step(1'b0,1'b1,3'd0,3'd5,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,8'h00,16'd1);
        step(1'b0,1'b1,3'd0,3'd5,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,8'h00,16'd1);
        // Branch during a would-be stall: flush wins, stall_cnt unchanged
        step(1'b0,1'b1,3'd0,3'd1,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0,8'h00,16'd1);
        step(1'b0,1'b1,3'd1,3'd2,1'b1,1'b0,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b1,8'h02,16'd1);
        step(1'b0,1'b0,3'd0,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,8'h00,16'd1);
        step(1'b0,1'b0,3'd0,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,8'h00,16'd1);
        // Branch inside FLUSH extends the flush
        step(1'b0,1'b0,3'd0,3'd0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,8'h00,16'd1);
        step(1'b0,1'b0,3'd0,3'd0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,8'h00,16'd1);
        step(1'b0,1'b0,3'd0,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,8'h00,16'd1);
        step(1'b0,1'b0,3'd0,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,8'h00,16'd1);
        // Reset in the second flush cycle clears everything
        step(1'b0,1'b1,3'd0,3'd5,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0,8'h00,16'd1);
        step(1'b0,1'b0,3'd0,3'd0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,8'h20,16'd1);
        step(1'b1,1'b0,3'd0,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,8'h00,16'd1);
        step(1'b0,1'b0,3'd0,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,8'h00,16'd0);
        // dst-as-source hazard
        step(1'b0,1'b1,3'd0,3'd7,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0,8'h00,16'd0);
        step(1'b0,1'b1,3'd0,3'd7,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h80,16'd0);
        step(1'b0,1'b1,3'd0,3'd7,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,8'h00,16'd1);
        // Unused source and invalid decode never stall
        step(1'b0,1'b1,3'd0,3'd6,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0,8'h00,16'd1);
        step(1'b0,1'b1,3'd6,3'd2,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,8'h40,16'd1);
        step(1'b0,1'b1,3'd0,3'd0,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0,8'h00,16'd1);
        step(1'b0,1'b0,3'd0,3'd0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,8'h01,16'd1);
        step(1'b0,1'b0,3'd0,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,8'h00,16'd1);
`endif
        repeat (2) @(posedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
